// File: rtl/uart_tx_drain_sched.sv
// uart_tx_drain_sched: drains the TX buffer between the read and write
// pointers and hands bytes one at a time to the UART serialiser.
module uart_tx_drain_sched #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    input  logic              tx_en_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] buffer_top,
    output logic [ADDR_W-1:0] buffer_bottom,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] buffer_output,
    input  logic              uart_ready,
    output logic [DATA_W-1:0] uart_value,
    output logic              uart_enable,
    output logic              busy_o,
    output logic [ADDR_W-1:0] level_o,
    output logic              empty_o,
    output logic              byte_sent_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_LATCH,
        ST_WAIT_READY,
        ST_SEND,
        ST_GUARD
    } state_t;

    state_t state;

    // Occupancy status; subtraction wraps naturally at ADDR_W bits
    assign level_o     = ADDR_W'(buffer_top - buffer_bottom);
    assign empty_o     = (buffer_top == buffer_bottom);
    assign mem_rd_addr = buffer_bottom;

    // Transfer sequencer: one byte per pass IDLE->READ->LATCH->WAIT_READY->SEND->GUARD
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state         <= ST_IDLE;
            buffer_bottom <= '0;
            uart_value    <= '0;
            uart_enable   <= 1'b0;
            mem_rd_en     <= 1'b0;
            byte_sent_o   <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a transition below re-asserts them
            mem_rd_en   <= 1'b0;
            uart_enable <= 1'b0;
            byte_sent_o <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (flush_i) begin
                        buffer_bottom <= buffer_top;
                    end else if (tx_en_i && !empty_o) begin
                        state     <= ST_READ;
                        mem_rd_en <= 1'b1;
                        busy_o    <= 1'b1;
                    end
                end

                ST_READ: begin
                    if (flush_i) begin
                        buffer_bottom <= buffer_top;
                        state         <= ST_IDLE;
                        busy_o        <= 1'b0;
                    end else begin
                        state <= ST_LATCH;
                    end
                end

                ST_LATCH: begin
                    if (flush_i) begin
                        buffer_bottom <= buffer_top;
                        state         <= ST_IDLE;
                        busy_o        <= 1'b0;
                    end else begin
                        uart_value <= buffer_output;
                        state      <= ST_WAIT_READY;
                    end
                end

                ST_WAIT_READY: begin
                    if (flush_i) begin
                        buffer_bottom <= buffer_top;
                        state         <= ST_IDLE;
                        busy_o        <= 1'b0;
                    end else if (uart_ready) begin
                        uart_enable <= 1'b1;
                        state       <= ST_SEND;
                    end
                end

                // Strobe is already on the wire; a flush only redirects the pointer
                ST_SEND: begin
                    if (flush_i) begin
                        buffer_bottom <= buffer_top;
                    end else begin
                        buffer_bottom <= buffer_bottom + ADDR_W'(1);
                    end
                    byte_sent_o <= 1'b1;
                    state       <= ST_GUARD;
                end

                // One dead cycle so the UART can drop uart_ready before IDLE looks again
                ST_GUARD: begin
                    if (flush_i) begin
                        buffer_bottom <= buffer_top;
                    end
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end

                default: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_drain_sched.sv
// Scoreboard bench for uart_tx_drain_sched: directed stimulus pushes expected
// bytes; a monitor pops and compares on every uart_enable strobe.
module tb_uart_tx_drain_sched;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 8;

    logic          clk;
    logic          rst_n;
    logic          tx_en;
    logic          flush;
    logic [AW-1:0] top;
    logic [AW-1:0] bottom;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          ready;
    logic [DW-1:0] value;
    logic          enable;
    logic          busy;
    logic [AW-1:0] level;
    logic          empty;
    logic          sent;

    logic [DW-1:0] mem [1024];
    logic [DW-1:0] exp_q [$];
    int            errors  = 0;
    int            checks  = 0;
    int            strobes = 0;
    logic          prev_en = 1'b0;

    uart_tx_drain_sched #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .wb_clk_i      (clk),
        .wb_rst_n_i    (rst_n),
        .tx_en_i       (tx_en),
        .flush_i       (flush),
        .buffer_top    (top),
        .buffer_bottom (bottom),
        .mem_rd_en     (rd_en),
        .mem_rd_addr   (rd_addr),
        .buffer_output (rd_data),
        .uart_ready    (ready),
        .uart_value    (value),
        .uart_enable   (enable),
        .busy_o        (busy),
        .level_o       (level),
        .empty_o       (empty),
        .byte_sent_o   (sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read buffer memory model
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every strobe must carry the next expected byte, and byte_sent follows it
    always @(negedge clk) begin
        if (rst_n && enable) begin
            strobes++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: value %0h with empty scoreboard at %0t", value, $time);
            end else begin
                check("uart_value", 32'(value), 32'(exp_q.pop_front()));
            end
        end
        if (rst_n && (prev_en || sent)) check("byte_sent_after_strobe", 32'(sent), 32'(prev_en));
        prev_en = enable;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_sent(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sent && n < budget);
        if (!sent) begin
            checks++;
            errors++;
            $display("FAIL wait_sent: byte_sent_o not seen within %0d cycles", budget);
        end
    endtask

    task automatic flush_pulse();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int base;
        logic saw_en;
        logic val_moved;
        logic saw_busy;
        foreach (mem[i]) mem[i] = '0;
        rst_n = 1'b0; tx_en = 1'b0; flush = 1'b0; top = '0; ready = 1'b0;
        rd_data = '0;
        cycles(3);
        check("rst_bottom", 32'(bottom), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_enable", 32'(enable), 0);
        check("rst_empty", 32'(empty), 1);
        rst_n = 1'b1;
        cycles(2);

        // Single byte, full latency trace
        mem[0] = 8'h55;
        exp_q.push_back(8'h55);
        top = 10'd1; tx_en = 1'b1; ready = 1'b1;
        #1 check("t2_level", 32'(level), 1);
        @(negedge clk);
        check("t2_rd_en", 32'(rd_en), 1);
        check("t2_rd_addr", 32'(rd_addr), 0);
        check("t2_busy", 32'(busy), 1);
        @(negedge clk);
        check("t2_rd_en_low", 32'(rd_en), 0);
        @(negedge clk);
        check("t2_value_latched", 32'(value), 32'h55);
        check("t2_enable_early", 32'(enable), 0);
        @(negedge clk);
        check("t2_enable_e3", 32'(enable), 1);
        @(negedge clk);
        check("t2_enable_single", 32'(enable), 0);
        check("t2_sent", 32'(sent), 1);
        check("t2_bottom", 32'(bottom), 1);
        check("t2_empty", 32'(empty), 1);
        @(negedge clk);
        check("t2_idle", 32'(busy), 0);

        // Pointer wrap across the top of the buffer
        tx_en = 1'b0;
        top = 10'd1023;
        flush_pulse();
        check("t3_bottom_set", 32'(bottom), 1023);
        mem[1023] = 8'hA1; mem[0] = 8'hB2;
        exp_q.push_back(8'hA1); exp_q.push_back(8'hB2);
        top = 10'd1;
        #1 check("t3_level2", 32'(level), 2);
        tx_en = 1'b1;
        wait_sent(20);
        check("t3_level1", 32'(level), 1);
        check("t3_bottom_wrap", 32'(bottom), 0);
        wait_sent(20);
        check("t3_level0", 32'(level), 0);
        check("t3_bottom_end", 32'(bottom), 1);
        cycles(1);

        // Backpressure in WAIT_READY
        ready = 1'b0;
        mem[1] = 8'h3C;
        exp_q.push_back(8'h3C);
        top = 10'd2;
        cycles(3);
        saw_en = 1'b0; val_moved = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (enable) saw_en = 1'b1;
            if (value !== 8'h3C) val_moved = 1'b1;
        end
        check("t4_no_strobe_while_busy", 32'(saw_en), 0);
        check("t4_value_stable", 32'(val_moved), 0);
        base = strobes;
        ready = 1'b1;
        @(negedge clk);
        check("t4_strobe_after_ready", 32'(enable), 1);
        wait_sent(5);
        check("t4_bottom", 32'(bottom), 2);
        check("t4_strobe_count", 32'(strobes - base), 1);
        cycles(1);

        // Flush in WAIT_READY discards everything without a strobe
        tx_en = 1'b0;
        top = 10'd0;
        flush_pulse();
        check("t5_bottom_zero", 32'(bottom), 0);
        mem[0] = 8'h11;
        ready = 1'b0;
        top = 10'd10; tx_en = 1'b1;
        base = strobes;
        cycles(3);
        check("t5_busy_wait", 32'(busy), 1);
        check("t5_value_wait", 32'(value), 32'h11);
        flush_pulse();
        check("t5_bottom_flushed", 32'(bottom), 10);
        check("t5_empty", 32'(empty), 1);
        check("t5_busy_cleared", 32'(busy), 0);
        check("t5_no_strobe", 32'(strobes - base), 0);

        // Flush in SEND: strobe still issues, pointer jumps to top
        mem[10] = 8'h7E;
        exp_q.push_back(8'h7E);
        ready = 1'b1;
        top = 10'd13;
        cycles(4);
        check("t5_send_strobe", 32'(enable), 1);
        flush_pulse();
        check("t5_send_sent", 32'(sent), 1);
        check("t5_send_bottom", 32'(bottom), 13);
        check("t5_send_empty", 32'(empty), 1);
        check("t5_send_one_strobe", 32'(strobes - base), 1);
        cycles(1);
        check("t5_send_idle", 32'(busy), 0);

        // tx_en dropped mid-transfer: byte completes, then the block parks
        mem[13] = 8'h21; mem[14] = 8'h22; mem[15] = 8'h23;
        exp_q.push_back(8'h21);
        base = strobes;
        top = 10'd16;
        cycles(2);
        tx_en = 1'b0;
        wait_sent(10);
        check("t6_bottom_after_first", 32'(bottom), 14);
        saw_busy = 1'b0;
        @(negedge clk);
        repeat (10) begin
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
        end
        check("t6_parked", 32'(saw_busy), 0);
        check("t6_level_parked", 32'(level), 2);
        check("t6_one_strobe", 32'(strobes - base), 1);
        exp_q.push_back(8'h22); exp_q.push_back(8'h23);
        tx_en = 1'b1;
        wait_sent(10);
        wait_sent(10);
        check("t6_level_done", 32'(level), 0);
        cycles(1);

        // Asynchronous reset in WAIT_READY
        mem[16] = 8'h99;
        ready = 1'b0;
        top = 10'd17;
        cycles(3);
        check("t1_pre_value", 32'(value), 32'h99);
        base = strobes;
        #2 rst_n = 1'b0;
        #1;
        check("t1_async_busy", 32'(busy), 0);
        check("t1_async_value", 32'(value), 0);
        check("t1_async_bottom", 32'(bottom), 0);
        check("t1_async_enable", 32'(enable), 0);
        check("t1_async_rd_en", 32'(rd_en), 0);
        top = 10'd0;
        ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        cycles(3);
        check("t1_post_busy", 32'(busy), 0);
        check("t1_post_bottom", 32'(bottom), 0);
        check("t1_no_strobe", 32'(strobes - base), 0);

        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_drain_sched.md
Name: uart_tx_drain_sched

Overview:
Sequences the transmit path of the buffered UART: drains bytes from the TX buffer memory between the read pointer (buffer_bottom) and the write pointer (buffer_top), and hands them one at a time to the UART transmitter over the uart_value/uart_enable/uart_ready handshake. It owns and publishes the read pointer. It sits between the Wishbone-side buffer writer and the UART serialiser, and exposes level and empty status for the register file.

Parameters:
ADDR_W, 10, buffer pointer/address width; buffer depth is 2^ADDR_W bytes
DATA_W, 8, byte width

Ports:
wb_clk_i  in  1  system clock
wb_rst_n_i  in  1  asynchronous, active-low reset
tx_en_i  in  1  drain enable from control register; level-sensitive
flush_i  in  1  one-cycle pulse; discards all pending bytes
buffer_top  in  ADDR_W  write pointer, owned by the buffer writer
buffer_bottom  out  ADDR_W  read pointer, owned by this block
mem_rd_en  out  1  buffer memory read strobe
mem_rd_addr  out  ADDR_W  buffer memory read address
buffer_output  in  DATA_W  memory read data; valid one cycle after mem_rd_en
uart_ready  in  1  UART idle and able to accept a byte
uart_value  out  DATA_W  byte presented to the UART
uart_enable  out  1  one-cycle start strobe to the UART
busy_o  out  1  high when the state is not IDLE
level_o  out  ADDR_W  pending bytes: (buffer_top - buffer_bottom) mod 2^ADDR_W
empty_o  out  1  buffer_top == buffer_bottom
byte_sent_o  out  1  one-cycle pulse per committed byte

Behaviour:
- Reset (asynchronous assert, synchronous release) sets: state IDLE, buffer_bottom 0, uart_value 0, uart_enable 0, mem_rd_en 0, byte_sent_o 0, busy_o 0. Reset mid-transfer aborts immediately and does not pulse uart_enable.
- level_o and empty_o are combinational from the pointers. Pointer arithmetic wraps modulo 2^ADDR_W. Distinguishing a full buffer is the writer's responsibility; maximum occupancy is 2^ADDR_W - 1.
- mem_rd_addr always equals buffer_bottom.
- States:
  - IDLE: go to READ when tx_en_i=1 and empty_o=0.
  - READ: mem_rd_en=1 for this cycle only; go to LATCH.
  - LATCH: capture buffer_output into uart_value; go to WAIT_READY.
  - WAIT_READY: hold uart_value stable; go to SEND when uart_ready=1.
  - SEND: uart_enable=1 for exactly one cycle; buffer_bottom increments on the exit edge; go to GUARD.
  - GUARD: byte_sent_o=1; uart_ready is ignored for this cycle so the UART can drop it; go to IDLE.
- Latency: if IDLE samples non-empty at edge E0, uart_enable is high in the cycle after edge E3, provided uart_ready is high. Steady-state throughput is at most one byte per 6 cycles, further bounded by the UART.
- uart_value changes only in LATCH. It is never changed while uart_enable is high.
- tx_en_i going low only stops new bytes from starting in IDLE. A byte already past IDLE completes through GUARD.
- flush_i:
  - In IDLE, READ, LATCH or WAIT_READY: buffer_bottom <= buffer_top and state <= IDLE. No uart_enable is issued.
  - In SEND: the strobe still issues, but buffer_bottom <= buffer_top instead of incrementing, and state continues to GUARD.
  - In GUARD: buffer_bottom <= buffer_top.
  - byte_sent_o fires only for strobes that were actually issued.
- A buffer_top change during a transfer has no effect on the byte in flight. It is seen in IDLE.
- uart_enable is never asserted while uart_ready=0.

Test Plan:
1. Assert wb_rst_n_i=0 mid-WAIT_READY -> all outputs take their reset values asynchronously; after release, state IDLE and buffer_bottom=0.
2. mem[0]=0x55, buffer_top 0->1, uart_ready=1, tx_en_i=1 -> mem_rd_en with addr 0, then uart_value=0x55 with a single uart_enable cycle at E3+1, byte_sent_o the next cycle, buffer_bottom=1, empty_o=1.
3. Wrap: buffer_bottom=1023, buffer_top=1, mem[1023]=0xA1, mem[0]=0xB2 -> two strobes carrying 0xA1 then 0xB2; level_o goes 2->1->0; buffer_bottom ends at 1.
4. Backpressure: uart_ready=0 for 20 cycles during WAIT_READY -> uart_enable stays 0, uart_value stays stable; one strobe follows within 1 cycle of uart_ready rising.
5. buffer_top=10, buffer_bottom=0, flush_i pulsed in WAIT_READY -> no uart_enable, buffer_bottom=10, empty_o=1, busy_o=0 next cycle; flush_i in SEND -> exactly one strobe, buffer_bottom=buffer_top.
6. Three bytes pending, tx_en_i dropped during LATCH of byte 1 -> byte 1 completes (one strobe, one byte_sent_o), then the block stays in IDLE with level_o=2 until tx_en_i returns.
